temp_seg_display: RTL
=====================

# temp_seg_display

Four-digit multiplexed 7-segment driver for the board temperature readout. It consumes the 3-digit BCD temperature word from the DS18B20Z reader: tens, ones and tenths in °C, 0.0–39.9 range. It renders that word as "TT.T C" on a common-anode/cathode LED module. Each input update is captured once per scan frame so no frame mixes digits from two readings.

## Interface
- `CLK_FREQ`, 12_000_000: clk frequency in Hz.
- `SCAN_HZ`, 1000: digit-switch rate in Hz. `PER = CLK_FREQ/SCAN_HZ` clocks per digit; `PER ≥ 4` is required.
- `BLANK_CYC`, 16: anti-ghosting off-time at the start of each digit slot, in clocks. `BLANK_CYC < PER` is required.
- `SEG_ACT_LOW`, 1: 1 means segment lines are active-low.
- `DIG_ACT_LOW`, 1: 1 means digit enables are active-low.
- `clk` input, 1 bit: system clock. There is one clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `en` input, 1 bit: capture enable. While low, the displayed value is frozen.
- `temp_bcd` input, 12 bits: [11:8] tens, [7:4] ones, [3:0] tenths, in BCD.
- `seg` output, 8 bits: [0]=a … [6]=g, [7]=dp. Polarity is set by `SEG_ACT_LOW`.
- `dig` output, 4 bits: digit enables, [0]=leftmost. Polarity is set by `DIG_ACT_LOW`.

## Operation
- Glyphs are given as logical codes, 1 = lit, before polarity inversion: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F, C=39, dash=40, blank=00.
- Prescaler `pcnt`, range 0..PER-1, free-running.
  - `tick` is asserted when `pcnt==PER-1`. On tick, `pcnt` returns to 0.
- Digit index `idx`, range 0..3, advances on tick. It wraps from 3 to 0.
- Shadow register `shd` (12 bits) is loaded from `temp_bcd` on the tick where `idx==3`, and only if `en` is 1 that cycle.
  - With `en` low, `shd` holds its value.
  - `temp_bcd` is sampled nowhere else.
- Content of each digit slot:
  - idx 0 (tens): blank if `shd[11:8]==0`, which is leading-zero suppression. Otherwise the digit.
  - idx 1 (ones): the digit with dp lit. It is never blanked, so 0 shows as "0.".
  - idx 2 (tenths): the digit.
  - idx 3: glyph C.
- Any nibble > 9 in slots 0–2 shows a dash (40). The ones slot keeps its dp. A tens nibble > 9 shows a dash, not blank.
- Ghosting guard: while `pcnt < BLANK_CYC`, logical seg=00 and no digit is enabled.
- Registered outputs:
  - `seg_r <= enc(idx, shd) ^ {8{SEG_ACT_LOW}}`, or all-inactive during blanking.
  - `dig_r <= onehot(idx) ^ {4{DIG_ACT_LOW}}`, or all-inactive during blanking.
- State machine, implicit in `idx` and `pcnt`:
  - BLANK (`pcnt < BLANK_CYC`) goes to SHOW (`pcnt ≥ BLANK_CYC`).
  - SHOW goes to BLANK on tick, with `idx` advanced.

## Timing
- Reset (asynchronous, while `rst`=1):
  - pcnt=0, idx=0, shd=000.
  - seg = all inactive: 8'hFF with the default polarity.
  - dig = all inactive: 4'hF with the default polarity.
- First digit enable asserts `BLANK_CYC+1` clocks after `rst` deasserts. The +1 is the output register.
- Output latency: `seg`/`dig` reflect `pcnt`/`idx`/`shd` with exactly 1 clk delay. `seg` and `dig` change on the same edge.
- Each digit is lit for `PER-BLANK_CYC` clocks per frame. Frame length is `4·PER` clocks.
- Update latency: a `temp_bcd` value stable at the idx 3→0 tick is shown starting at the next digit-0 SHOW. If `en` is low at that tick, the update is missed until the following frame, up to `8·PER` clocks.
- `temp_bcd` changing mid-frame has no effect on the current frame. There is no tearing.
- Reset mid-frame forces the reset values immediately, asynchronously. Scanning restarts at idx 0 with shd=000.
  - With shd=000, the display after reset is " 0.0C": tens blanked.

## Test plan
Simulation parameters: `CLK_FREQ`=1000, `SCAN_HZ`=100 (PER=10), `BLANK_CYC`=2, default polarities.

1. **Reset.** Assert `rst` mid-frame.
   - Required: seg=FF and dig=F in the same cycle.
   - After release: dig=E (digit 0 enabled) appears at clock 3 with seg=FF (blank tens), then dig=D with seg=~BF=40.
2. **Normal value.** temp_bcd=0x235, en=1.
   - Required over one frame: dig E/D/B/7 with seg ~5B=A4, ~CF=30, ~6D=92, ~39=C6.
   - Each digit is enabled 8 clocks and blanked 2.
3. **Leading zero and dash.** temp_bcd=0x09A.
   - Required: tens slot seg=FF, ones slot ~EF=10, tenths slot ~40=BF.
4. **Freeze.** Display 0x235, drop `en`, then change temp_bcd to 0x301 for 3 frames.
   - Required: the display remains 0x235.
   - After `en`=1: 0x301 appears from the next frame start, never earlier.
5. **No tearing.** Change temp_bcd from 0x111 to 0x222 while idx=1.
   - Required: the current frame shows all-1 digits; the next frame shows all-2 digits.
6. **Polarity.** `SEG_ACT_LOW`=0, `DIG_ACT_LOW`=0, value 0x235.
   - Required: seg=5B with dig=1 on the first SHOW.
   - During blanking and reset: seg=00, dig=0.

Source files
------------

// File: rtl/temp_seg_if.sv
// temp_seg_if
// Bundle between the temperature source and the 4-digit 7-segment scanner.
// Handshake: there is none. temp_bcd/en are level signals sampled by the
// display only at the frame boundary (idx 3 -> 0 tick). seg/dig are
// registered, free-running outputs.
//   en        capture enable, source -> display
//   temp_bcd  {tens, ones, tenths} BCD, source -> display
//   seg       segment lines {dp,g..a}, display -> LED module
//   dig       digit enables, [0]=leftmost, display -> LED module
//   show      debug: scanner phase, 1 = SHOW, 0 = BLANK (pre-register)
interface temp_seg_if;
   logic        en;
   logic [11:0] temp_bcd;
   logic [7:0]  seg;
   logic [3:0]  dig;
   logic        show;

   modport master (
      output en,
      output temp_bcd,
      input  seg,
      input  dig,
      input  show
   );

   modport slave (
      input  en,
      input  temp_bcd,
      output seg,
      output dig,
      output show
   );
endinterface

// File: rtl/temp_seg_display.sv
// temp_seg_display
// Multiplexed 4-digit 7-segment driver rendering a BCD temperature as "TT.T C".
// A shadow register captures the input once per frame so a frame never mixes
// two readings. Each digit slot begins with BLANK_CYC clocks of all-off time
// to suppress ghosting.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  temp_seg_if.slave: en, temp_bcd in; seg, dig, show out
module temp_seg_display #(
   parameter int CLK_FREQ    = 12_000_000,
   parameter int SCAN_HZ     = 1000,
   parameter int BLANK_CYC   = 16,
   parameter int SEG_ACT_LOW = 1,
   parameter int DIG_ACT_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   temp_seg_if.slave  bus
);

   localparam int PER = CLK_FREQ / SCAN_HZ;
   localparam int PW  = (PER > 1) ? $clog2(PER) : 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(PER - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
   // All-inactive levels; XOR with these also applies the polarity.
   localparam logic [7:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [3:0] DIG_OFF = (DIG_ACT_LOW != 0) ? 4'hF : 4'h0;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

   logic [PW-1:0] pcnt, pcnt_d;
   logic [1:0]    idx, idx_d;
   logic [11:0]   shd, shd_d;
   logic [7:0]    seg_r, seg_d;
   logic [3:0]    dig_r, dig_d;
   logic          tick;
   logic [7:0]    glyph_on;
   logic [3:0]    onehot;
   state_t        state;

   // Logical glyph, 1 = lit. Non-BCD nibbles render as a dash.
   function automatic logic [7:0] glyph(input logic [3:0] n);
      case (n)
         4'd0:    glyph = 8'h3F;
         4'd1:    glyph = 8'h06;
         4'd2:    glyph = 8'h5B;
         4'd3:    glyph = 8'h4F;
         4'd4:    glyph = 8'h66;
         4'd5:    glyph = 8'h6D;
         4'd6:    glyph = 8'h7D;
         4'd7:    glyph = 8'h07;
         4'd8:    glyph = 8'h7F;
         4'd9:    glyph = 8'h6F;
         default: glyph = 8'h40;
      endcase
   endfunction

   // Slot content from the shadow copy, never from the live input.
   always_comb begin
      glyph_on = 8'h00;
      case (idx)
         // Leading-zero suppression only for a true 0; a bad nibble is a dash.
         2'd0:    glyph_on = (shd[11:8] == 4'd0) ? 8'h00 : glyph(shd[11:8]);
         2'd1:    glyph_on = glyph(shd[7:4]) | 8'h80;
         2'd2:    glyph_on = glyph(shd[3:0]);
         default: glyph_on = 8'h39;
      endcase
   end

   // Next-state and output decode. The scanner phase is implied by pcnt.
   always_comb begin
      state  = (pcnt < BLANK_END) ? ST_BLANK : ST_SHOW;
      tick   = (pcnt == PCNT_LAST);
      pcnt_d = tick ? '0 : pcnt + 1'b1;
      idx_d  = tick ? idx + 2'd1 : idx;
      shd_d  = shd;
      if (tick && (idx == 2'd3) && bus.en) begin
         shd_d = bus.temp_bcd;
      end
      onehot = 4'b0001 << idx;
      seg_d  = SEG_OFF;
      dig_d  = DIG_OFF;
      if (state == ST_SHOW) begin
         seg_d = glyph_on ^ SEG_OFF;
         dig_d = onehot ^ DIG_OFF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt  <= '0;
         idx   <= 2'd0;
         shd   <= 12'h000;
         seg_r <= SEG_OFF;
         dig_r <= DIG_OFF;
      end else begin
         pcnt  <= pcnt_d;
         idx   <= idx_d;
         shd   <= shd_d;
         seg_r <= seg_d;
         dig_r <= dig_d;
      end
   end

   assign bus.seg  = seg_r;
   assign bus.dig  = dig_r;
   assign bus.show = (state == ST_SHOW);

endmodule
